// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache tag array:
//   - default geometry constants (ways, sets, tag width)
//   - the flush-walk FSM state type
// Optional feature macro used elsewhere in this slice: ICACHE_TAG_PARITY_EN.
// -----------------------------------------------------------------------------
package icache_pkg;

   localparam int DEF_WAYS  = 2;
   localparam int DEF_SETS  = 256;
   localparam int DEF_TAG_W = 20;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/icache_tag_way.sv
// -----------------------------------------------------------------------------
// icache_tag_way
// One way of the tag array: a synchronous-read tag RAM plus a valid-bit array
// with a dedicated clear port used by the flush walk. Tag storage is never
// reset; only the valid bits are cleared (through clr_*).
//
// Ports
//   clk_i                     clock
//   rd_en_i, rd_idx_i         read request; data appears on rd_* next cycle
//   wr_en_i, wr_idx_i,
//   wr_tag_i                  write tag and set valid
//   clr_en_i, clr_idx_i       clear the valid bit of one set (wins over write)
//   rd_valid_o, rd_tag_o      registered read data
//   rd_par_err_o              (ICACHE_TAG_PARITY_EN only) parity check of the
//                             registered read entry
// -----------------------------------------------------------------------------
module icache_tag_way
   import icache_pkg::*;
#(
   parameter int SETS  = DEF_SETS,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic                     clk_i,
   input  logic                     rd_en_i,
   input  logic [$clog2(SETS)-1:0]  rd_idx_i,
   input  logic                     wr_en_i,
   input  logic [$clog2(SETS)-1:0]  wr_idx_i,
   input  logic [TAG_W-1:0]         wr_tag_i,
   input  logic                     clr_en_i,
   input  logic [$clog2(SETS)-1:0]  clr_idx_i,
   output logic                     rd_valid_o,
   output logic [TAG_W-1:0]         rd_tag_o
`ifdef ICACHE_TAG_PARITY_EN
   ,
   output logic                     rd_par_err_o
`endif
);

   logic [TAG_W-1:0] tag_mem_q [SETS];
   logic [SETS-1:0]  valid_mem_q;
   logic [TAG_W-1:0] rd_tag_q;
   logic             rd_valid_q;

   // Non-blocking write plus registered read gives read-before-write when
   // the same set is read and written in one cycle.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) tag_mem_q[wr_idx_i] <= wr_tag_i;
      if (rd_en_i) rd_tag_q <= tag_mem_q[rd_idx_i];
   end

   always_ff @(posedge clk_i) begin
      if (clr_en_i)     valid_mem_q[clr_idx_i] <= 1'b0;
      else if (wr_en_i) valid_mem_q[wr_idx_i]  <= 1'b1;
      if (rd_en_i) rd_valid_q <= valid_mem_q[rd_idx_i];
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_tag_o   = rd_tag_q;

`ifdef ICACHE_TAG_PARITY_EN
   logic par_mem_q [SETS];
   logic rd_par_q;

   // Even parity over {valid, tag}. Entries are only ever written with
   // valid=1, so the stored bit is computed for valid=1 and the check is
   // applied to valid entries only (cleared entries keep stale tags).
   always_ff @(posedge clk_i) begin
      if (wr_en_i) par_mem_q[wr_idx_i] <= ^{1'b1, wr_tag_i};
      if (rd_en_i) rd_par_q <= par_mem_q[rd_idx_i];
   end

   assign rd_par_err_o = rd_valid_q & (^{rd_valid_q, rd_tag_q, rd_par_q});
`endif

endmodule

// File: rtl/icache_tag_array.sv
// -----------------------------------------------------------------------------
// icache_tag_array
// Set-associative I-cache tag array with 1-cycle lookup, round-robin victim
// pointer per set, and an invalidate-all flush walk (one set per cycle).
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   lookup_i, lookup_idx_i,
//   lookup_tag_i                 lookup request; result next cycle
//   hit_o, hit_way_o             lookup result (hit_way_o = 0 on miss)
//   victim_way_o                 round-robin victim of the looked-up set
//   fill_i, fill_idx_i,
//   fill_way_i, fill_tag_i       write tag + set valid, advance victim pointer
//   flush_i                      start invalidate-all walk
//   busy_o                       flush walk in progress
//   dbg_state_o                  current FSM state (observation only)
//   parity_err_o                 (ICACHE_TAG_PARITY_EN only) parity error,
//                                aligned with hit_o
//
// Request semantics: lookup_i, fill_i and flush_i are single-cycle requests
// taken only in a cycle where busy_o=0; while busy_o=1 they are dropped, not
// held, so a requester must re-issue after busy_o falls.
// -----------------------------------------------------------------------------
module icache_tag_array
   import icache_pkg::*;
#(
   parameter  int WAYS  = DEF_WAYS,
   parameter  int SETS  = DEF_SETS,
   parameter  int TAG_W = DEF_TAG_W,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lookup_i,
   input  logic [IDX_W-1:0]  lookup_idx_i,
   input  logic [TAG_W-1:0]  lookup_tag_i,
   output logic              hit_o,
   output logic [WAY_W-1:0]  hit_way_o,
   output logic [WAY_W-1:0]  victim_way_o,
   input  logic              fill_i,
   input  logic [IDX_W-1:0]  fill_idx_i,
   input  logic [WAY_W-1:0]  fill_way_i,
   input  logic [TAG_W-1:0]  fill_tag_i,
   input  logic              flush_i,
   output logic              busy_o,
   output state_t            dbg_state_o
`ifdef ICACHE_TAG_PARITY_EN
   ,
   output logic              parity_err_o
`endif
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               busy;
   logic               lookup_ok;
   logic               fill_ok;

   assign busy      = (state_q == ST_FLUSH);
   assign lookup_ok = lookup_i & ~busy;
   assign fill_ok   = fill_i & ~busy;

   // ---------------- flush FSM ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_FLUSH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_i) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
         ST_FLUSH: begin
            // flush_i is not looked at here: a re-flush never restarts the walk
            if (cnt_q == IDX_W'(SETS - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy_o      = busy;
   assign dbg_state_o = state_q;

   // ---------------- lookup pipeline register ----------------
   logic             lookup_q;
   logic [TAG_W-1:0] tag_q;
   logic [WAY_W-1:0] victim_q;
   logic [WAY_W-1:0] vptr_q [SETS];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lookup_q <= 1'b0;
         tag_q    <= '0;
         victim_q <= '0;
      end else begin
         lookup_q <= lookup_ok;
         tag_q    <= lookup_tag_i;
         victim_q <= lookup_ok ? vptr_q[lookup_idx_i] : '0;
      end
   end

   // Victim pointers are cleared by the walk, not by reset.
   always_ff @(posedge clk_i) begin
      if (busy) begin
         vptr_q[cnt_q] <= '0;
      end else if (fill_ok) begin
         vptr_q[fill_idx_i] <= (vptr_q[fill_idx_i] == WAY_W'(WAYS - 1)) ?
                               '0 : vptr_q[fill_idx_i] + 1'b1;
      end
   end

   assign victim_way_o = victim_q;

   // ---------------- ways ----------------
   logic [WAYS-1:0]  rd_valid;
   logic [TAG_W-1:0] rd_tag [WAYS];
   logic [WAYS-1:0]  match;
`ifdef ICACHE_TAG_PARITY_EN
   logic [WAYS-1:0]  par_err;
`endif

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic wr_sel;
      assign wr_sel = (WAYS == 1) ? 1'b1 : (fill_way_i == WAY_W'(w));

      icache_tag_way #(
         .SETS  (SETS),
         .TAG_W (TAG_W)
      ) u_way (
         .clk_i        (clk_i),
         .rd_en_i      (lookup_ok),
         .rd_idx_i     (lookup_idx_i),
         .wr_en_i      (fill_ok & wr_sel),
         .wr_idx_i     (fill_idx_i),
         .wr_tag_i     (fill_tag_i),
         .clr_en_i     (busy),
         .clr_idx_i    (cnt_q),
         .rd_valid_o   (rd_valid[w]),
         .rd_tag_o     (rd_tag[w])
`ifdef ICACHE_TAG_PARITY_EN
         ,
         .rd_par_err_o (par_err[w])
`endif
      );

      assign match[w] = rd_valid[w] & (rd_tag[w] == tag_q);
   end

   // A duplicate tag in two ways is treated as a miss, so a hit has exactly
   // one matching way and the lowest-index scan selects it.
   logic             one_match;
   logic             any_par_err;
   logic [WAY_W-1:0] low_way;

   assign one_match = ($countones(match) == 1);

   always_comb begin
      low_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) low_way = WAY_W'(w);
      end
   end

`ifdef ICACHE_TAG_PARITY_EN
   assign any_par_err  = lookup_q & (|par_err);
   assign parity_err_o = any_par_err;
`else
   assign any_par_err  = 1'b0;
`endif

   assign hit_o     = lookup_q & one_match & ~any_par_err;
   assign hit_way_o = hit_o ? low_way : '0;

endmodule

// File: tb/tb_icache_tag_array.sv
// -----------------------------------------------------------------------------
// tb_icache_tag_array
// Directed bench for icache_tag_array (default geometry: 2 ways, 256 sets,
// 20-bit tags). A cache-level model tracks contents, victim pointers and the
// busy window; a negedge process compares every output every cycle, and the
// directed sequence adds hand-computed literal checks.
// Optional macro: ICACHE_TAG_PARITY_EN enables the parity scenario.
// -----------------------------------------------------------------------------
module tb_icache_tag_array;
   import icache_pkg::*;

   localparam int WAYS  = 2;
   localparam int SETS  = 256;
   localparam int TAG_W = 20;

   // ---------------- clock / reset ----------------
   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             lookup_i = 1'b0;
   logic [7:0]       lookup_idx_i = '0;
   logic [TAG_W-1:0] lookup_tag_i = '0;
   logic             fill_i = 1'b0;
   logic [7:0]       fill_idx_i = '0;
   logic [0:0]       fill_way_i = '0;
   logic [TAG_W-1:0] fill_tag_i = '0;
   logic             flush_i = 1'b0;
   logic             hit_o;
   logic [0:0]       hit_way_o;
   logic [0:0]       victim_way_o;
   logic             busy_o;
   state_t           dbg_state_o;
`ifdef ICACHE_TAG_PARITY_EN
   logic             parity_err_o;
`endif

   always #5 clk_i = ~clk_i;

   icache_tag_array #(
      .WAYS  (WAYS),
      .SETS  (SETS),
      .TAG_W (TAG_W)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .lookup_i     (lookup_i),
      .lookup_idx_i (lookup_idx_i),
      .lookup_tag_i (lookup_tag_i),
      .hit_o        (hit_o),
      .hit_way_o    (hit_way_o),
      .victim_way_o (victim_way_o),
      .fill_i       (fill_i),
      .fill_idx_i   (fill_idx_i),
      .fill_way_i   (fill_way_i),
      .fill_tag_i   (fill_tag_i),
      .flush_i      (flush_i),
      .busy_o       (busy_o),
      .dbg_state_o  (dbg_state_o)
`ifdef ICACHE_TAG_PARITY_EN
      ,
      .parity_err_o (parity_err_o)
`endif
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit               m_valid   [WAYS][SETS];
   logic [TAG_W-1:0] m_tag     [WAYS][SETS];
   bit               m_corrupt [WAYS][SETS];
   int               m_vptr    [SETS];
   int               busy_left = SETS;
   bit               exp_hit   = 0;
   int               exp_way   = 0;
   int               exp_vict  = 0;
   bit               exp_perr  = 0;

   task automatic model_clear();
      for (int s = 0; s < SETS; s++) begin
         m_vptr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[w][s] = 0;
      end
   endtask

   always @(posedge clk_i) begin : model
      int nm;
      int first;
      bit perr;
      if (rst_i) begin
         busy_left = SETS;
         model_clear();
         exp_hit = 0; exp_way = 0; exp_vict = 0; exp_perr = 0;
      end else if (busy_left > 0) begin
         busy_left--;
         exp_hit = 0; exp_way = 0; exp_vict = 0; exp_perr = 0;
      end else begin
         exp_hit = 0; exp_way = 0; exp_vict = 0; exp_perr = 0;
         if (lookup_i) begin
            nm = 0; first = -1; perr = 0;
            for (int w = 0; w < WAYS; w++) begin
               if (m_valid[w][lookup_idx_i] && m_corrupt[w][lookup_idx_i]) perr = 1;
               else if (m_valid[w][lookup_idx_i] && m_tag[w][lookup_idx_i] == lookup_tag_i) begin
                  nm++;
                  if (first < 0) first = w;
               end
            end
            exp_hit  = (nm == 1) && !perr;
            exp_way  = exp_hit ? first : 0;
            exp_vict = m_vptr[lookup_idx_i];
            exp_perr = perr;
         end
         if (fill_i) begin
            m_valid[fill_way_i][fill_idx_i]   = 1;
            m_tag[fill_way_i][fill_idx_i]     = fill_tag_i;
            m_corrupt[fill_way_i][fill_idx_i] = 0;
            m_vptr[fill_idx_i] = (m_vptr[fill_idx_i] + 1) % WAYS;
         end
         if (flush_i) begin
            busy_left = SETS;
            model_clear();
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk_i) begin
      if (rst_i) begin
         check("rst_busy",   busy_o, 1);
         check("rst_hit",    hit_o, 0);
         check("rst_hitway", hit_way_o, 0);
         check("rst_victim", victim_way_o, 0);
      end else begin
         check("cyc_busy",   busy_o, busy_left > 0);
         check("cyc_state",  dbg_state_o, (busy_left > 0) ? ST_FLUSH : ST_IDLE);
         check("cyc_hit",    hit_o, exp_hit);
         check("cyc_hitway", hit_way_o, exp_way);
         check("cyc_victim", victim_way_o, exp_vict);
`ifdef ICACHE_TAG_PARITY_EN
         check("cyc_perr",   parity_err_o, exp_perr);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_lookup(input logic [7:0] idx, input logic [TAG_W-1:0] tag);
      lookup_i = 1'b1; lookup_idx_i = idx; lookup_tag_i = tag;
      step();
      lookup_i = 1'b0;
   endtask

   task automatic do_fill(input logic [7:0] idx, input logic [0:0] way, input logic [TAG_W-1:0] tag);
      fill_i = 1'b1; fill_idx_i = idx; fill_way_i = way; fill_tag_i = tag;
      step();
      fill_i = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      #1 rst_i = 1'b1;
      repeat (3) step();
      check("reset_busy",   busy_o, 1);
      check("reset_hit",    hit_o, 0);
      check("reset_victim", victim_way_o, 0);

      // reset walk must last exactly SETS cycles
      rst_i = 1'b0;
      n = 0;
      while (busy_o && n < 1000) begin
         n++;
         step();
      end
      check("reset_walk_cycles", n, 256);

      do_lookup(8'h00, 20'h12345);
      check("empty_lookup_hit", hit_o, 0);

      do_fill(8'h10, 1'b1, 20'hABCDE);
      do_lookup(8'h10, 20'hABCDE);
      check("fill10_hit",    hit_o, 1);
      check("fill10_hitway", hit_way_o, 1);
      check("fill10_victim", victim_way_o, 1);
      do_lookup(8'h10, 20'hABCDF);
      check("fill10_tagdiff_hit", hit_o, 0);
      check("fill10_tagdiff_way", hit_way_o, 0);

      // fill and lookup of the same set in one cycle: pre-fill contents
      lookup_i = 1'b1; lookup_idx_i = 8'h20; lookup_tag_i = 20'h11111;
      fill_i   = 1'b1; fill_idx_i   = 8'h20; fill_way_i   = 1'b0; fill_tag_i = 20'h11111;
      step();
      lookup_i = 1'b0; fill_i = 1'b0;
      check("rbw_hit",    hit_o, 0);
      check("rbw_victim", victim_way_o, 0);
      do_lookup(8'h20, 20'h11111);
      check("rbw_later_hit",    hit_o, 1);
      check("rbw_later_victim", victim_way_o, 1);

      // victim pointer: 0,1,0,1 across three fills
      do_lookup(8'h30, 20'h30002);
      check("vict_seq0", victim_way_o, 0);
      do_fill(8'h30, 1'b0, 20'h30000);
      do_lookup(8'h30, 20'h30002);
      check("vict_seq1", victim_way_o, 1);
      do_fill(8'h30, 1'b1, 20'h30001);
      do_lookup(8'h30, 20'h30002);
      check("vict_seq2", victim_way_o, 0);
      do_fill(8'h30, 1'b0, 20'h30002);
      do_lookup(8'h30, 20'h30002);
      check("vict_seq3", victim_way_o, 1);
      check("vict_seq3_hit", hit_o, 1);
      check("vict_seq3_way", hit_way_o, 0);

      // same tag in both ways is not a hit
      do_fill(8'h50, 1'b0, 20'h55555);
      do_fill(8'h50, 1'b1, 20'h55555);
      do_lookup(8'h50, 20'h55555);
      check("dup_tag_hit", hit_o, 0);
      check("dup_tag_way", hit_way_o, 0);

      // flush: requests during the walk are dropped, re-flush ignored
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      n = 0;
      while (busy_o && n < 1000) begin
         fill_i = (n == 10); fill_idx_i = 8'h60; fill_way_i = 1'b0; fill_tag_i = 20'h66666;
         flush_i = (n == 10);
         lookup_i = (n == 10); lookup_idx_i = 8'h10; lookup_tag_i = 20'hABCDE;
         n++;
         step();
      end
      fill_i = 1'b0; flush_i = 1'b0; lookup_i = 1'b0;
      check("flush_walk_cycles", n, 256);
      do_lookup(8'h10, 20'hABCDE);
      check("after_flush_10", hit_o, 0);
      do_lookup(8'h20, 20'h11111);
      check("after_flush_20", hit_o, 0);
      do_lookup(8'h30, 20'h30002);
      check("after_flush_30_hit",    hit_o, 0);
      check("after_flush_30_victim", victim_way_o, 0);
      do_lookup(8'h60, 20'h66666);
      check("busy_fill_dropped", hit_o, 0);

      // reset in the middle of a flush walk restarts it
      do_fill(8'h70, 1'b0, 20'h77777);
      do_lookup(8'h70, 20'h77777);
      check("pre_reset_hit", hit_o, 1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      repeat (99) step();
      rst_i = 1'b1;
      step();
      check("midflush_rst_busy", busy_o, 1);
      rst_i = 1'b0;
      n = 0;
      while (busy_o && n < 1000) begin
         fill_i = (n == 5); fill_idx_i = 8'h71; fill_way_i = 1'b1; fill_tag_i = 20'h71717;
         n++;
         step();
      end
      fill_i = 1'b0;
      check("midflush_rst_walk_cycles", n, 256);
      do_lookup(8'h71, 20'h71717);
      check("rst_busy_fill_dropped", hit_o, 0);
      do_lookup(8'h70, 20'h77777);
      check("rst_cleared_70", hit_o, 0);

`ifdef ICACHE_TAG_PARITY_EN
      do_fill(8'h40, 1'b0, 20'h44444);
      dut.g_way[0].u_way.tag_mem_q[8'h40] = 20'h44445;
      m_corrupt[0][8'h40] = 1;
      do_lookup(8'h40, 20'h44444);
      check("parity_hit",  hit_o, 0);
      check("parity_err",  parity_err_o, 1);
      step();
      check("parity_err_pulse", parity_err_o, 0);
`endif

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
